wb_mem_bist: RTL
================

WB_MEM_BIST -- requirements
Module: wb_mem_bist

Interface
REQ-001 SHALL have parameter APP_AW, default 26, Wishbone byte-address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter BL, default 8, beats per burst; legal range is 1..16.
REQ-004 SHALL have port sys_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to run a test.
REQ-007 SHALL have port base_addr, input, APP_AW bits: first byte address tested.
REQ-008 SHALL have port num_bursts, input, 16 bits: number of bursts in each phase.
REQ-009 SHALL have port seed, input, DW bits: pattern seed.
REQ-010 SHALL have the Wishbone master outputs wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_addr_o (APP_AW), wb_dat_o (DW), wb_sel_o (DW/8) and wb_cti_o (3).
REQ-011 SHALL have the Wishbone master inputs wb_ack_i (1) and wb_dat_i (DW).
REQ-012 SHALL have status outputs busy (1), done (1), pass (1), err_cnt (16) and first_err_addr (APP_AW).

Function
REQ-013 Block SHALL be the Wishbone initiator for the SDRAM controller slave: write a pattern region, then read it back and compare.
REQ-014 FSM states SHALL be IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP and DONE.
REQ-015 start SHALL be sampled in IDLE or DONE. The next cycle: state=WR_BURST, cyc/stb/we=1, addr=base_addr, status cleared, busy=1, done=0.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 Beat index g SHALL count from 0 across the whole phase.
REQ-018 Beat g SHALL use address base_addr + g*(DW/8), modulo 2^APP_AW (wraps silently).
REQ-019 Beat g SHALL use data seed + g, modulo 2^DW.
REQ-020 wb_sel_o SHALL be all ones whenever stb=1.
REQ-021 Within a burst, each beat SHALL hold addr, dat and cti stable until wb_ack_i=1.
REQ-022 On ack, the beat SHALL advance on the next cycle with cyc and stb still high; wait states are unbounded.
REQ-023 cti SHALL be 3'b010 for beats 0..BL-2 and 3'b111 for the last beat; for BL=1, cti SHALL be 3'b000.
REQ-024 After the last beat's ack, cyc and stb SHALL drop for exactly one cycle (WR_GAP/RD_GAP), then the next burst starts.
REQ-025 After WR_GAP following burst num_bursts-1, the FSM SHALL enter RD_BURST with g=0 and we=0.
REQ-026 In RD_BURST, on each ack the block SHALL compare wb_dat_i with the expected data (seed + g).
REQ-027 On a mismatch, err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-028 On the first mismatch, first_err_addr SHALL capture that beat's address; it SHALL hold otherwise.
REQ-029 After the final read burst's RD_GAP, the FSM SHALL enter DONE: busy=0, done=1, pass=(err_cnt==0). These SHALL hold until the next start.
REQ-030 num_bursts=0 SHALL make start go IDLE->DONE in one cycle with pass=1 and no bus cycles.
REQ-031 wb_dat_o SHALL be 0 and wb_we_o SHALL be 0 whenever wb_cyc_o=0.
REQ-032 An ack while stb=0 SHALL be ignored.

Reset
REQ-033 resetn=0 SHALL asynchronously force IDLE and set every output to 0: cyc, stb, we, addr, dat, sel, cti, busy, done, pass, err_cnt, first_err_addr.
REQ-034 Reset mid-burst SHALL drop cyc/stb immediately; no burst resumes after release.
REQ-035 After release, the first action SHALL be a fresh start.

Verification
REQ-036 Zero-wait slave, BL=8, num_bursts=2, base=0x100, seed=0xA5A50000 -> 16 writes at 0x100..0x13C, cti pattern 010x7 then 111, one-cycle gaps, 16 reads, done=1, pass=1, err_cnt=0.
REQ-037 Slave inserting 3 wait states per beat -> addr, dat and cti held 4 cycles per beat; final result identical to REQ-036.
REQ-038 Slave corrupts read beat g=5 -> err_cnt=1, first_err_addr=0x114, pass=0.
REQ-039 base=2^26-8, num_bursts=1, BL=4 -> addresses 0x3FFFFF8, 0x3FFFFFC, 0x0, 0x4.
REQ-040 num_bursts=0 -> done one cycle after start, no cyc; start pulsed while busy -> no effect.
REQ-041 resetn dropped during a read burst -> all outputs 0 in the same cycle; a new start afterwards runs cleanly with pass=1.

Source files
------------

// File: rtl/wb_mem_bist.sv
// Wishbone memory BIST initiator: writes an incrementing pattern over a region
// in bursts, then reads it back and counts mismatches.
module wb_mem_bist #(
    parameter int unsigned APP_AW = 26,
    parameter int unsigned DW     = 32,
    parameter int unsigned BL     = 8
) (
    input  logic              sys_clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [APP_AW-1:0] base_addr,
    input  logic [15:0]       num_bursts,
    input  logic [DW-1:0]     seed,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [APP_AW-1:0] first_err_addr
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned BW = 5;
    localparam logic [BW-1:0] LAST_BEAT   = BW'(BL - 1);
    localparam logic [2:0]    CTI_CLASSIC = 3'b000;
    localparam logic [2:0]    CTI_INC     = 3'b010;
    localparam logic [2:0]    CTI_END     = 3'b111;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        WR_GAP   = 3'd2,
        RD_BURST = 3'd3,
        RD_GAP   = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [BW-1:0]       beat, beat_nxt;
    logic [15:0]         burst, burst_nxt;
    logic [15:0]         nb_q, nb_nxt;
    logic [APP_AW-1:0]   base_q, base_nxt;
    logic [DW-1:0]       seed_q, seed_nxt;
    logic [DW-1:0]       pat, pat_nxt;
    logic                cyc_nxt, stb_nxt, we_nxt;
    logic [APP_AW-1:0]   addr_nxt;
    logic [DW-1:0]       dat_nxt;
    logic [SW-1:0]       sel_nxt;
    logic [2:0]          cti_nxt;
    logic                busy_nxt, done_nxt, pass_nxt;
    logic [15:0]         err_nxt;
    logic [APP_AW-1:0]   fe_nxt;
    logic                last_burst_c;

    // Burst type for a given beat position; single-beat bursts are classic cycles
    function automatic logic [2:0] cti_for(input logic [BW-1:0] b);
        if (BL == 1)
            return CTI_CLASSIC;
        else if (b == LAST_BEAT)
            return CTI_END;
        else
            return CTI_INC;
    endfunction

    assign last_burst_c = (burst == nb_q - 16'd1);

    // State and all registered outputs
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            beat           <= '0;
            burst          <= '0;
            nb_q           <= '0;
            base_q         <= '0;
            seed_q         <= '0;
            pat            <= '0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_addr_o      <= '0;
            wb_dat_o       <= '0;
            wb_sel_o       <= '0;
            wb_cti_o       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
        end else begin
            state          <= state_nxt;
            beat           <= beat_nxt;
            burst          <= burst_nxt;
            nb_q           <= nb_nxt;
            base_q         <= base_nxt;
            seed_q         <= seed_nxt;
            pat            <= pat_nxt;
            wb_cyc_o       <= cyc_nxt;
            wb_stb_o       <= stb_nxt;
            wb_we_o        <= we_nxt;
            wb_addr_o      <= addr_nxt;
            wb_dat_o       <= dat_nxt;
            wb_sel_o       <= sel_nxt;
            wb_cti_o       <= cti_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            err_cnt        <= err_nxt;
            first_err_addr <= fe_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        burst_nxt = burst;
        nb_nxt    = nb_q;
        base_nxt  = base_q;
        seed_nxt  = seed_q;
        pat_nxt   = pat;
        cyc_nxt   = wb_cyc_o;
        stb_nxt   = wb_stb_o;
        we_nxt    = wb_we_o;
        addr_nxt  = wb_addr_o;
        dat_nxt   = wb_dat_o;
        sel_nxt   = wb_sel_o;
        cti_nxt   = wb_cti_o;
        busy_nxt  = busy;
        done_nxt  = done;
        pass_nxt  = pass;
        err_nxt   = err_cnt;
        fe_nxt    = first_err_addr;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nb_nxt   = num_bursts;
                    base_nxt = base_addr;
                    seed_nxt = seed;
                    err_nxt  = '0;
                    fe_nxt   = '0;
                    beat_nxt = '0;
                    burst_nxt = '0;
                    if (num_bursts == 16'd0) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = 1'b1;
                    end else begin
                        state_nxt = WR_BURST;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        pass_nxt  = 1'b0;
                        cyc_nxt   = 1'b1;
                        stb_nxt   = 1'b1;
                        we_nxt    = 1'b1;
                        addr_nxt  = base_addr;
                        dat_nxt   = seed;
                        pat_nxt   = seed;
                        sel_nxt   = '1;
                        cti_nxt   = cti_for('0);
                    end
                end
            end

            WR_BURST, RD_BURST: begin
                if (wb_ack_i && wb_stb_o) begin
                    addr_nxt = wb_addr_o + APP_AW'(SW);
                    pat_nxt  = pat + DW'(1);
                    if (state == RD_BURST && wb_dat_i != pat) begin
                        if (err_cnt != 16'hFFFF)
                            err_nxt = err_cnt + 16'd1;
                        if (err_cnt == 16'd0)
                            fe_nxt = wb_addr_o;
                    end
                    if (beat == LAST_BEAT) begin
                        state_nxt = (state == WR_BURST) ? WR_GAP : RD_GAP;
                        beat_nxt  = '0;
                        cyc_nxt   = 1'b0;
                        stb_nxt   = 1'b0;
                        we_nxt    = 1'b0;
                        dat_nxt   = '0;
                        sel_nxt   = '0;
                        cti_nxt   = '0;
                    end else begin
                        beat_nxt = beat + BW'(1);
                        cti_nxt  = cti_for(beat + BW'(1));
                        dat_nxt  = (state == WR_BURST) ? pat + DW'(1) : '0;
                    end
                end
            end

            WR_GAP: begin
                cyc_nxt = 1'b1;
                stb_nxt = 1'b1;
                sel_nxt = '1;
                cti_nxt = cti_for('0);
                if (last_burst_c) begin
                    state_nxt = RD_BURST;
                    burst_nxt = '0;
                    we_nxt    = 1'b0;
                    dat_nxt   = '0;
                    addr_nxt  = base_q;
                    pat_nxt   = seed_q;
                end else begin
                    state_nxt = WR_BURST;
                    burst_nxt = burst + 16'd1;
                    we_nxt    = 1'b1;
                    dat_nxt   = pat;
                end
            end

            RD_GAP: begin
                if (last_burst_c) begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_cnt == 16'd0);
                end else begin
                    state_nxt = RD_BURST;
                    burst_nxt = burst + 16'd1;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    sel_nxt   = '1;
                    cti_nxt   = cti_for('0);
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
